// File: rtl/lu_pkg.sv
// lu_pkg: opcode constants and sequencer state encoding shared by the lu_sequencer slice.
package lu_pkg;
   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/lu_settle_counter.sv
// lu_settle_counter: loadable down-counter that stops at zero and flags it.
module lu_settle_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);
   logic [W-1:0] count;
   assign zero = count == '0;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (en && !zero) count <= count - 1'b1;
endmodule

// File: rtl/lu_sequencer.sv
// lu_sequencer: issues one command to an external logic unit, holds its inputs SETTLE cycles,
// then captures lu_f and offers it as a response.
module lu_sequencer
   import lu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_chain,
   input  logic [WIDTH-1:0] cmd_x,
   input  logic [WIDTH-1:0] cmd_y,
   output logic [WIDTH-1:0] lu_x,
   output logic [WIDTH-1:0] lu_y,
   output logic             lu_sel1,
   output logic             lu_sel0,
   input  logic [WIDTH-1:0] lu_f,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f,
   output logic [1:0]       rsp_op,
   output logic             busy
);
   state_t state, state_nx;
   logic alive, accept, cap, zero;
   logic [WIDTH-1:0] last_result;
   // alive keeps cmd_ready low until the first edge after reset releases
   assign cmd_ready = alive && state == IDLE;
   assign accept    = cmd_valid && cmd_ready;
   assign cap       = state == DRIVE && zero;
   assign busy      = state != IDLE;
   assign rsp_valid = state == RESP;
   always_comb begin
      state_nx = state;
      state_nx = accept ? DRIVE : cap ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
   end
   lu_settle_counter #(.W(4)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (4'(SETTLE - 1)),
      .en       (state == DRIVE),
      .zero     (zero)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         alive       <= 1'b0;
         lu_x        <= '0;
         lu_y        <= '0;
         lu_sel1     <= 1'b0;
         lu_sel0     <= 1'b0;
         rsp_f       <= '0;
         rsp_op      <= '0;
         last_result <= '0;
      end else begin
         state <= state_nx;
         alive <= 1'b1;
         if (accept) begin
            lu_x               <= cmd_chain ? last_result : cmd_x;
            lu_y               <= cmd_y;
            {lu_sel1, lu_sel0} <= cmd_op;
         end
         if (cap) begin
            rsp_f       <= lu_f;
            rsp_op      <= {lu_sel1, lu_sel0};
            last_result <= lu_f;
         end
      end
endmodule

// File: tb/tb_lu_sequencer.sv
// tb_lu_sequencer: random and directed commands against a reference model, SETTLE=1 and SETTLE=4.
module tb_lu_sequencer;
   import lu_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   logic       cmd_valid = 0, cmd_chain = 0, rsp_ready = 0;
   logic [1:0] cmd_op = 0;
   logic [7:0] cmd_x = 0, cmd_y = 0, lu_x, lu_y, lu_f, rsp_f;
   logic       cmd_ready, lu_sel1, lu_sel0, rsp_valid, busy;
   logic [1:0] rsp_op;
   logic       c4_valid = 0, c4_rsp_ready = 0;
   logic [7:0] c4_x = 0, c4_y = 0, lu_f4 = 0, lu_x4, lu_y4, rsp_f4;
   logic       c4_ready, sel41, sel40, rsp_valid4, busy4;
   logic [1:0] rsp_op4;
   logic [7:0] last_ref = 0;

   lu_sequencer #(.WIDTH(8), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_chain(cmd_chain), .cmd_x(cmd_x), .cmd_y(cmd_y), .lu_x(lu_x), .lu_y(lu_y),
      .lu_sel1(lu_sel1), .lu_sel0(lu_sel0), .lu_f(lu_f), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_f(rsp_f), .rsp_op(rsp_op), .busy(busy));
   lu_sequencer #(.WIDTH(8), .SETTLE(4)) dut4 (
      .clk(clk), .rst(rst), .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_op(OP_XOR),
      .cmd_chain(1'b0), .cmd_x(c4_x), .cmd_y(c4_y), .lu_x(lu_x4), .lu_y(lu_y4),
      .lu_sel1(sel41), .lu_sel0(sel40), .lu_f(lu_f4), .rsp_valid(rsp_valid4),
      .rsp_ready(c4_rsp_ready), .rsp_f(rsp_f4), .rsp_op(rsp_op4), .busy(busy4));

   function automatic logic [7:0] op_ref(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
      case (op)
         OP_OR:   return x | y;
         OP_AND:  return x & y;
         OP_XOR:  return x ^ y;
         default: return ~x;
      endcase
   endfunction
   // stand-in for the external logic unit
   assign lu_f = op_ref({lu_sel1, lu_sel0}, lu_x, lu_y);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic ch, input logic [7:0] x,
                          input logic [7:0] y, input int hold);
      logic [7:0] xe, ex;
      int n;
      xe = ch ? last_ref : x;
      ex = op_ref(op, xe, y);
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      check("ready_wait", n < 50, 1);
      cmd_valid = 1; cmd_op = op; cmd_chain = ch; cmd_x = x; cmd_y = y;
      @(negedge clk);
      cmd_valid = 0; cmd_x = $urandom; cmd_y = $urandom;
      rsp_ready = 1'($urandom);
      check("lu_x", lu_x, xe);
      check("lu_y", lu_y, y);
      check("lu_sel", {lu_sel1, lu_sel0}, op);
      check("drive_flags", {busy, cmd_ready, rsp_valid}, 3'b100);
      @(negedge clk);
      rsp_ready = 0;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_f", rsp_f, ex);
      check("rsp_op", rsp_op, op);
      last_ref = ex;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1; cmd_x = $urandom;
         @(negedge clk);
         check("hold_state", {rsp_valid, cmd_ready, busy}, 3'b101);
         check("hold_f", rsp_f, ex);
         check("hold_lu_x", lu_x, xe);
      end
      cmd_valid = 0; rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check("back_idle", {rsp_valid, cmd_ready, busy}, 3'b010);
   endtask

   initial begin
      #1;
      check("rst_flags", {cmd_ready, busy, rsp_valid}, 3'b000);
      check("rst_out", {lu_x, lu_y, lu_sel1, lu_sel0, rsp_f, rsp_op}, 0);
      @(negedge clk); @(negedge clk);
      rst = 0;
      #1 check("ready_before_edge", cmd_ready, 0);
      @(negedge clk);
      check("ready_after_edge", cmd_ready, 1);
      run_cmd(OP_OR, 1, 8'h6C, 8'h17, 0);
      check("chain_after_reset", lu_x, 8'h00);
      run_cmd(OP_OR,  0, 8'h6C, 8'h17, 0); check("v_or",  rsp_f, 8'h7F);
      run_cmd(OP_AND, 0, 8'h6C, 8'h17, 0); check("v_and", rsp_f, 8'h04);
      run_cmd(OP_XOR, 0, 8'h6C, 8'h17, 0); check("v_xor", rsp_f, 8'h7B);
      run_cmd(OP_NOT, 0, 8'h6C, 8'h17, 0); check("v_not", rsp_f, 8'h93);
      run_cmd(OP_XOR, 0, 8'h6C, 8'h17, 0);
      run_cmd(OP_AND, 1, 8'hAA, 8'h0F, 0);
      check("chain_lu_x", lu_x, 8'h7B); check("chain_f", rsp_f, 8'h0B);
      run_cmd(OP_OR, 0, 8'h12, 8'h34, 5);
      // reset in DRIVE abandons the command
      cmd_valid = 1; cmd_op = OP_OR; cmd_chain = 0; cmd_x = 8'h55; cmd_y = 8'hAA;
      @(negedge clk);
      cmd_valid = 0; rst = 1;
      #1 check("mid_rst_flags", {rsp_valid, busy, cmd_ready}, 3'b000);
      check("mid_rst_out", {lu_x, lu_y, lu_sel1, lu_sel0, rsp_f, rsp_op}, 0);
      @(negedge clk);
      rst = 0; last_ref = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_rsp_after_rst", rsp_valid, 0);
      end
      run_cmd(OP_NOT, 1, 8'h3C, 8'h00, 0);
      check("not_chain_ff", rsp_f, 8'hFF);
      for (int k = 0; k < 24; k++)
         run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 3));
      // SETTLE=4: only lu_f on the fourth DRIVE cycle may be captured
      for (int k = 0; k < 3; k++) begin
         logic [7:0] v;
         int n;
         v = 8'($urandom);
         n = 0;
         while (!c4_ready && n < 50) begin @(negedge clk); n++; end
         check("s4_ready_wait", n < 50, 1);
         c4_valid = 1; c4_x = 8'($urandom); c4_y = 8'($urandom);
         @(negedge clk);
         c4_valid = 0;
         for (int c = 1; c <= 4; c++) begin
            lu_f4 = (c == 4) ? v : 8'($urandom);
            check("s4_not_yet", {rsp_valid4, busy4}, 2'b01);
            @(negedge clk);
         end
         lu_f4 = ~v;
         check("s4_valid", rsp_valid4, 1);
         check("s4_f", rsp_f4, v);
         check("s4_op", rsp_op4, OP_XOR);
         c4_rsp_ready = 1;
         @(negedge clk);
         c4_rsp_ready = 0;
         check("s4_idle", {rsp_valid4, c4_ready}, 2'b01);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
